slot_alloc_tracker: RTL and testbench

Owns the occupancy bitmap of a WIDTH-entry structure (RS, ROB-side free list, LSQ) and is the consumer end of a priority-selector interface. It drives the free vector into the selector's request input and takes the selector's per-lane one-hot grant bus back. It then turns each accepted grant into a registered entry index, marks the entry busy, and retires entries on release.

---
 rtl/slot_alloc_tracker.sv | 139 +++++++++++++
 tb/tb_slot_alloc_tracker.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slot_alloc_tracker.sv
// slot_alloc_tracker
// Occupancy tracker for a WIDTH-entry structure. It presents the free vector
// to an external priority selector, accepts the per-lane one-hot grants that
// come back, and converts each accepted grant into a registered entry index
// while marking the entry busy. Release ports retire entries. Protocol
// violations are collected into a sticky flag.
module slot_alloc_tracker #(
   parameter int WIDTH    = 16,
   parameter int REQS     = 2,
   parameter int IDX_BITS = $clog2(WIDTH),
   parameter int CNT_BITS = $clog2(WIDTH + 1)
) (
   input  logic                     clock,
   input  logic                     reset,
   output logic [WIDTH-1:0]         free_vec,
   input  logic [WIDTH*REQS-1:0]    gnt_bus,
   input  logic [REQS-1:0]          alloc_req,
   output logic [REQS-1:0]          alloc_valid,
   output logic [REQS*IDX_BITS-1:0] alloc_idx,
   input  logic [REQS-1:0]          release_en,
   input  logic [REQS*IDX_BITS-1:0] release_idx,
   output logic [CNT_BITS-1:0]      free_count,
   output logic                     full,
   output logic                     empty,
   output logic                     proto_err
);

   // Binary encode of a one-hot grant; only meaningful when the input is one-hot.
   function automatic logic [IDX_BITS-1:0] encode_onehot(input logic [WIDTH-1:0] v);
      logic [IDX_BITS-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) r = r | IDX_BITS'(i);
      end
      return r;
   endfunction

   // Number of clear bits in the occupancy map.
   function automatic logic [CNT_BITS-1:0] count_free(input logic [WIDTH-1:0] b);
      logic [CNT_BITS-1:0] n;
      n = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (!b[i]) n = n + CNT_BITS'(1);
      end
      return n;
   endfunction

   logic [WIDTH-1:0]    busy_p1;
   logic [WIDTH-1:0]    busy_p0;
   logic [WIDTH-1:0]    lane_gnt_p0 [REQS];
   logic [IDX_BITS-1:0] lane_idx_p0 [REQS];
   logic [WIDTH-1:0]    claimed_p0;
   logic [WIDTH-1:0]    set_mask_p0;
   logic [WIDTH-1:0]    clr_mask_p0;
   logic [REQS-1:0]     acc_p0;
   logic                gnt_err_p0;
   logic                rel_err_p0;
   logic                rel_in_range_p0;

   // Status outputs depend on the busy register alone, so the selector loop
   // through free_vec -> gnt_bus never closes combinationally.
   always_comb begin
      free_vec   = ~busy_p1;
      free_count = count_free(busy_p1);
      full       = &busy_p1;
      empty      = ~|busy_p1;
   end

   // Grant qualification: a requested lane allocates only with a clean one-hot
   // grant on a free entry not already taken by a lower lane this cycle.
   always_comb begin
      claimed_p0  = '0;
      set_mask_p0 = '0;
      acc_p0      = '0;
      gnt_err_p0  = 1'b0;
      for (int j = 0; j < REQS; j++) begin
         lane_gnt_p0[j] = gnt_bus[j*WIDTH +: WIDTH];
         lane_idx_p0[j] = encode_onehot(lane_gnt_p0[j]);
         if (alloc_req[j] && (lane_gnt_p0[j] != '0)) begin
            if (!$onehot(lane_gnt_p0[j])) begin
               gnt_err_p0 = 1'b1;
            end else if (|(lane_gnt_p0[j] & busy_p1)) begin
               gnt_err_p0 = 1'b1;
            end else if (|(lane_gnt_p0[j] & claimed_p0)) begin
               gnt_err_p0 = 1'b1;
            end else begin
               acc_p0[j]   = 1'b1;
               claimed_p0  = claimed_p0 | lane_gnt_p0[j];
               set_mask_p0 = set_mask_p0 | lane_gnt_p0[j];
            end
         end
      end
   end

   // Release decode: an in-range index always clears its bit (so a release
   // beats a same-cycle allocation), but releasing a free entry or an
   // out-of-range index is flagged.
   always_comb begin
      clr_mask_p0     = '0;
      rel_err_p0      = 1'b0;
      rel_in_range_p0 = 1'b0;
      for (int k = 0; k < REQS; k++) begin
         rel_in_range_p0 = 1'b0;
         if (release_en[k]) begin
            for (int i = 0; i < WIDTH; i++) begin
               if (release_idx[k*IDX_BITS +: IDX_BITS] == IDX_BITS'(i)) begin
                  rel_in_range_p0 = 1'b1;
                  clr_mask_p0[i]  = 1'b1;
                  if (!busy_p1[i]) rel_err_p0 = 1'b1;
               end
            end
            if (!rel_in_range_p0) rel_err_p0 = 1'b1;
         end
      end
   end

   // Next occupancy: set accepted grants, then clear releases.
   always_comb begin
      busy_p0 = (busy_p1 | set_mask_p0) & ~clr_mask_p0;
   end

   // ---- stage p0 -> p1: occupancy, allocation results and sticky error ----
   always_ff @(posedge clock) begin
      if (reset) begin
         busy_p1     <= '0;
         alloc_valid <= '0;
         alloc_idx   <= '0;
         proto_err   <= 1'b0;
      end else begin
         busy_p1     <= busy_p0;
         alloc_valid <= acc_p0;
         for (int j = 0; j < REQS; j++) begin
            if (acc_p0[j]) alloc_idx[j*IDX_BITS +: IDX_BITS] <= lane_idx_p0[j];
         end
         proto_err   <= proto_err | gnt_err_p0 | rel_err_p0;
      end
   end

endmodule

// File: tb/tb_slot_alloc_tracker.sv
// Testbench for slot_alloc_tracker (WIDTH=8, REQS=2) with a scoreboard queue
// fed from a behavioural reference model.
module tb_slot_alloc_tracker;

   localparam int W  = 8;
   localparam int R  = 2;
   localparam int IB = 3;
   localparam int CB = 4;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [W-1:0]    free_vec;
   logic [W*R-1:0]  gnt_bus = '0;
   logic [R-1:0]    alloc_req = '0;
   logic [R-1:0]    alloc_valid;
   logic [R*IB-1:0] alloc_idx;
   logic [R-1:0]    release_en = '0;
   logic [R*IB-1:0] release_idx = '0;
   logic [CB-1:0]   free_count;
   logic            full;
   logic            empty;
   logic            proto_err;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string    tag;
      logic [1:0] av;
      logic [2:0] i0;
      logic [2:0] i1;
      logic [7:0] fv;
      logic [3:0] fc;
      logic       fu;
      logic       em;
      logic       pe;
   } exp_t;

   exp_t sb[$];

   // reference model state
   logic [7:0] m_busy = '0;
   logic [1:0] m_av   = '0;
   logic [2:0] m_i0   = '0;
   logic [2:0] m_i1   = '0;
   logic       m_pe   = 1'b0;

   slot_alloc_tracker #(.WIDTH(W), .REQS(R)) dut (
      .clock       (clock),
      .reset       (reset),
      .free_vec    (free_vec),
      .gnt_bus     (gnt_bus),
      .alloc_req   (alloc_req),
      .alloc_valid (alloc_valid),
      .alloc_idx   (alloc_idx),
      .release_en  (release_en),
      .release_idx (release_idx),
      .free_count  (free_count),
      .full        (full),
      .empty       (empty),
      .proto_err   (proto_err)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Behavioural model of one clock edge.
   task automatic model_step(input logic rst, input logic [1:0] req,
                             input logic [7:0] g0, input logic [7:0] g1,
                             input logic [1:0] ren, input logic [2:0] r0, input logic [2:0] r1);
      logic [7:0] gl [2];
      logic [7:0] used;
      logic [7:0] setm;
      logic [7:0] clr;
      logic [1:0] nav;
      logic       err;
      logic [2:0] ri;
      int         p;
      if (rst) begin
         m_busy = '0; m_av = '0; m_i0 = '0; m_i1 = '0; m_pe = 1'b0;
         return;
      end
      gl[0] = g0; gl[1] = g1;
      used = '0; setm = '0; clr = '0; nav = '0; err = 1'b0;
      for (int j = 0; j < 2; j++) begin
         if (req[j] && gl[j] != 8'h00) begin
            if ($countones(gl[j]) != 1) begin
               err = 1'b1;
            end else begin
               p = 0;
               for (int i = 0; i < 8; i++) if (gl[j][i]) p = i;
               if (m_busy[p] || used[p]) begin
                  err = 1'b1;
               end else begin
                  used[p] = 1'b1;
                  setm[p] = 1'b1;
                  nav[j]  = 1'b1;
                  if (j == 0) m_i0 = 3'(p); else m_i1 = 3'(p);
               end
            end
         end
      end
      for (int k = 0; k < 2; k++) begin
         if (ren[k]) begin
            ri = (k == 0) ? r0 : r1;
            clr[ri] = 1'b1;
            if (!m_busy[ri]) err = 1'b1;
         end
      end
      m_busy = (m_busy | setm) & ~clr;
      m_av   = nav;
      m_pe   = m_pe | err;
   endtask

   // Drive one cycle of stimulus, push the model's expectation, then compare
   // the scoreboard head against the DUT after the edge.
   task automatic cycle(input string tag, input logic rst, input logic [1:0] req,
                        input logic [7:0] g0, input logic [7:0] g1,
                        input logic [1:0] ren, input logic [2:0] r0, input logic [2:0] r1);
      exp_t e;
      reset       = rst;
      alloc_req   = req;
      gnt_bus     = {g1, g0};
      release_en  = ren;
      release_idx = {r1, r0};
      model_step(rst, req, g0, g1, ren, r0, r1);
      e.tag = tag; e.av = m_av; e.i0 = m_i0; e.i1 = m_i1;
      e.fv  = ~m_busy;
      e.fc  = 4'(8 - $countones(m_busy));
      e.fu  = (m_busy == 8'hFF);
      e.em  = (m_busy == 8'h00);
      e.pe  = m_pe;
      sb.push_back(e);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      check_eq({e.tag, ".av"}, 32'(alloc_valid), 32'(e.av));
      if (e.av[0]) check_eq({e.tag, ".idx0"}, 32'(alloc_idx[2:0]), 32'(e.i0));
      if (e.av[1]) check_eq({e.tag, ".idx1"}, 32'(alloc_idx[5:3]), 32'(e.i1));
      check_eq({e.tag, ".fv"}, 32'(free_vec), 32'(e.fv));
      check_eq({e.tag, ".fc"}, 32'(free_count), 32'(e.fc));
      check_eq({e.tag, ".full"}, 32'(full), 32'(e.fu));
      check_eq({e.tag, ".empty"}, 32'(empty), 32'(e.em));
      check_eq({e.tag, ".perr"}, 32'(proto_err), 32'(e.pe));
   endtask

   task automatic do_reset();
      cycle("rst", 1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 3'd0, 3'd0);
   endtask

   task automatic idle(input string tag);
      cycle(tag, 1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 3'd0, 3'd0);
   endtask

   function automatic logic [7:0] lowest_free(input logic [7:0] b);
      for (int i = 0; i < 8; i++) if (!b[i]) return 8'(1 << i);
      return 8'h00;
   endfunction

   function automatic logic [7:0] highest_free(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) if (!b[i]) return 8'(1 << i);
      return 8'h00;
   endfunction

   initial begin
      logic [7:0] g0;
      logic [7:0] g1;

      // 1: reset and idle
      do_reset();
      do_reset();
      idle("idle");
      check_eq("tp1_fv", 32'(free_vec), 32'h FF);
      check_eq("tp1_fc", 32'(free_count), 32'd8);
      check_eq("tp1_empty", 32'(empty), 32'd1);
      check_eq("tp1_full", 32'(full), 32'd0);
      check_eq("tp1_av", 32'(alloc_valid), 32'd0);
      check_eq("tp1_perr", 32'(proto_err), 32'd0);

      // 2: two lanes allocate opposite ends
      cycle("tp2", 1'b0, 2'b11, 8'h80, 8'h01, 2'b00, 3'd0, 3'd0);
      check_eq("tp2_av", 32'(alloc_valid), 32'd3);
      check_eq("tp2_idx0", 32'(alloc_idx[2:0]), 32'd7);
      check_eq("tp2_idx1", 32'(alloc_idx[5:3]), 32'd0);
      check_eq("tp2_fv", 32'(free_vec), 32'h7E);
      check_eq("tp2_fc", 32'(free_count), 32'd6);
      check_eq("tp2_empty", 32'(empty), 32'd0);

      // 3: fill from reset with selector-style grants
      do_reset();
      for (int c = 0; c < 4; c++) begin
         cycle("tp3_fill", 1'b0, 2'b11, lowest_free(m_busy), highest_free(m_busy), 2'b00, 3'd0, 3'd0);
      end
      check_eq("tp3_full", 32'(full), 32'd1);
      check_eq("tp3_fv", 32'(free_vec), 32'h00);
      check_eq("tp3_fc", 32'(free_count), 32'd0);
      cycle("tp3_nogrant", 1'b0, 2'b11, 8'h00, 8'h00, 2'b00, 3'd0, 3'd0);
      check_eq("tp3_av", 32'(alloc_valid), 32'd0);
      check_eq("tp3_perr", 32'(proto_err), 32'd0);

      // 4: release one entry from full and reuse it next cycle
      cycle("tp4_rel", 1'b0, 2'b00, 8'h00, 8'h00, 2'b01, 3'd3, 3'd0);
      check_eq("tp4_fv", 32'(free_vec), 32'h08);
      check_eq("tp4_fc", 32'(free_count), 32'd1);
      cycle("tp4_reuse", 1'b0, 2'b01, 8'h08, 8'h00, 2'b00, 3'd0, 3'd0);
      check_eq("tp4_av", 32'(alloc_valid), 32'd1);
      check_eq("tp4_idx0", 32'(alloc_idx[2:0]), 32'd3);
      check_eq("tp4_full", 32'(full), 32'd1);

      // 5a: multi-hot grant
      do_reset();
      cycle("tp5a", 1'b0, 2'b01, 8'h03, 8'h00, 2'b00, 3'd0, 3'd0);
      check_eq("tp5a_av", 32'(alloc_valid), 32'd0);
      check_eq("tp5a_fv", 32'(free_vec), 32'h FF);
      check_eq("tp5a_perr", 32'(proto_err), 32'd1);
      idle("tp5a_sticky");
      check_eq("tp5a_sticky", 32'(proto_err), 32'd1);

      // 5b: both lanes grant the same entry
      do_reset();
      cycle("tp5b", 1'b0, 2'b11, 8'h10, 8'h10, 2'b00, 3'd0, 3'd0);
      check_eq("tp5b_av", 32'(alloc_valid), 32'd1);
      check_eq("tp5b_idx0", 32'(alloc_idx[2:0]), 32'd4);
      check_eq("tp5b_fv", 32'(free_vec), 32'hEF);
      check_eq("tp5b_perr", 32'(proto_err), 32'd1);

      // 5c: release of a free entry
      do_reset();
      cycle("tp5c", 1'b0, 2'b00, 8'h00, 8'h00, 2'b01, 3'd5, 3'd0);
      check_eq("tp5c_fv", 32'(free_vec), 32'h FF);
      check_eq("tp5c_perr", 32'(proto_err), 32'd1);

      // grant hitting a busy entry
      do_reset();
      cycle("busy_a", 1'b0, 2'b01, 8'h20, 8'h00, 2'b00, 3'd0, 3'd0);
      cycle("busy_b", 1'b0, 2'b10, 8'h00, 8'h20, 2'b00, 3'd0, 3'd0);
      check_eq("busyhit_av", 32'(alloc_valid), 32'd0);
      check_eq("busyhit_perr", 32'(proto_err), 32'd1);

      // release of an entry allocated in the same cycle: release wins
      do_reset();
      cycle("samecyc", 1'b0, 2'b01, 8'h04, 8'h00, 2'b01, 3'd2, 3'd0);
      check_eq("samecyc_fv", 32'(free_vec), 32'h FF);
      check_eq("samecyc_perr", 32'(proto_err), 32'd1);

      // duplicate release indices clear once without error
      do_reset();
      cycle("dup_alloc", 1'b0, 2'b11, 8'h02, 8'h20, 2'b00, 3'd0, 3'd0);
      cycle("dup_rel", 1'b0, 2'b00, 8'h00, 8'h00, 2'b11, 3'd1, 3'd1);
      check_eq("duprel_fv", 32'(free_vec), 32'hDF);
      check_eq("duprel_perr", 32'(proto_err), 32'd0);

      // unrequested lanes carrying grants are ignored
      cycle("unreq", 1'b0, 2'b00, 8'h01, 8'h80, 2'b00, 3'd0, 3'd0);
      check_eq("unreq_av", 32'(alloc_valid), 32'd0);
      check_eq("unreq_fv", 32'(free_vec), 32'hDF);

      // 6: reset wins over live grants
      do_reset();
      cycle("tp6_a", 1'b0, 2'b11, 8'h01, 8'h02, 2'b00, 3'd0, 3'd0);
      cycle("tp6_b", 1'b0, 2'b01, 8'h04, 8'h00, 2'b00, 3'd0, 3'd0);
      cycle("tp6_rst", 1'b1, 2'b11, 8'h08, 8'h10, 2'b00, 3'd0, 3'd0);
      check_eq("tp6_av", 32'(alloc_valid), 32'd0);
      check_eq("tp6_fv", 32'(free_vec), 32'hFF);
      check_eq("tp6_fc", 32'(free_count), 32'd8);
      check_eq("tp6_perr", 32'(proto_err), 32'd0);

      // randomized traffic against the model
      do_reset();
      for (int c = 0; c < 80; c++) begin
         g0 = lowest_free(m_busy);
         g1 = highest_free(m_busy);
         if ($urandom_range(0, 9) == 0) g0 = 8'($urandom);
         if ($urandom_range(0, 9) == 0) g1 = 8'($urandom);
         cycle("rand", 1'b0, 2'($urandom), g0, g1, 2'($urandom_range(0, 3) == 0 ? 2'($urandom) : 2'b00),
               3'($urandom), 3'($urandom));
         if (c == 40) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
